mag_comp_seq: RTL

//  Multi-cycle, parametrised magnitude comparator; successor to the 4-bit combinational comparator.

---
 rtl/mag_comp_pkg.sv | 15 +
 rtl/mag_comp_seq_slice_cmp.sv | 27 ++
 rtl/mag_comp_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mag_comp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package mag_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices that make up a WIDTH-bit operand.
    function automatic int nslice(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/mag_comp_seq_slice_cmp.sv
// Combinational CHUNK-bit unsigned compare of one operand slice.
// flip_msb inverts the MSB of both slices, which turns a two's-complement
// top slice into an order-preserving unsigned compare.
module slice_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             flip_msb,
    output logic             gt,
    output logic             lt
);

    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] xm;
    logic [CHUNK-1:0] ym;

    // Optional sign-bit flip followed by a plain unsigned compare.
    always_comb begin
        xm = x ^ ({CHUNK{flip_msb}} & MSB_MASK);
        ym = y ^ ({CHUNK{flip_msb}} & MSB_MASK);
        gt = (xm > ym);
        lt = (xm < ym);
    end

endmodule

// File: rtl/mag_comp_seq.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle,
// MSB slice first, with optional early exit at the first differing slice.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; held flags still visible
// RUN   | comparing slice idx_q, counting idx_q down to 0
// DONE  | one-cycle done pulse, flags just updated; accepts start
module mag_comp_seq
    import mag_comp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b
);

    localparam int NSLICE = nslice(WIDTH, CHUNK);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("mag_comp_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    // First-decision tracking for full scans: dec_q set once a slice differed.
    logic             dec_q, dec_d;
    logic             pgt_q, pgt_d;
    logic             plt_q, plt_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic [CHUNK-1:0] sa;
    logic [CHUNK-1:0] sb;
    logic             flip;
    logic             s_gt;
    logic             s_lt;
    logic             res_gt;
    logic             res_lt;

    // Select the current slice of both operands; sign handling on the top slice only.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) begin
                sa = a_q[i*CHUNK +: CHUNK];
                sb = b_q[i*CHUNK +: CHUNK];
            end
        end
        flip = sgn_q && (idx_q == IDX_TOP);
    end

    slice_cmp #(.CHUNK(CHUNK)) u_slice_cmp (
        .x        (sa),
        .y        (sb),
        .flip_msb (flip),
        .gt       (s_gt),
        .lt       (s_lt)
    );

    // Next-state, capture, down-counter and result logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        pgt_d   = pgt_q;
        plt_d   = plt_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        res_gt  = dec_q ? pgt_q : s_gt;
        res_lt  = dec_q ? plt_q : s_lt;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    idx_d   = IDX_TOP;
                    dec_d   = 1'b0;
                    pgt_d   = 1'b0;
                    plt_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!dec_q && (s_gt || s_lt)) begin
                    dec_d = 1'b1;
                    pgt_d = s_gt;
                    plt_d = s_lt;
                end
                if (idx_q == '0 || (EARLY_EXIT != 0 && (s_gt || s_lt))) begin
                    state_d = DONE;
                    gt_d    = res_gt;
                    lt_d    = res_lt;
                    eq_d    = !res_gt && !res_lt;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            pgt_q   <= 1'b0;
            plt_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            pgt_q   <= pgt_d;
            plt_q   <= plt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign a_gt_b = gt_q;
    assign a_lt_b = lt_q;
    assign a_eq_b = eq_q;

endmodule
